// File: rtl/accum_ctrl_pkg.sv
// Shared types and constants for the wordcount accumulator job sequencer.
package accum_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_CLRWAIT  = 3'd2,
    ST_RUN      = 3'd3,
    ST_FLUSH    = 3'd4,
    ST_DUMP_RD  = 3'd5,
    ST_DUMP_OUT = 3'd6
  } state_t;

  localparam int FLUSH_CYCLES = 4;
  localparam int COUNT_WIDTH  = 32;
  localparam logic [COUNT_WIDTH-1:0] INC_VALUE = 32'd1;

  // Lane after 'lane' in an n-way rotation.
  function automatic int next_lane(input int lane, input int n);
    return (lane + 1 >= n) ? 0 : lane + 1;
  endfunction

endpackage

// File: rtl/accum_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after i_ptr.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  int w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N) w_cand = w_cand - N;
      if (!o_any && i_req[w_cand]) begin
        o_any           = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = PW'(w_cand);
      end
    end
  end

endmodule

// File: rtl/accum_ctrl.sv
// Job sequencer and round-robin front end for the wordcount accumulator array.
// Build option ACCUM_CTRL_SKIP_ZERO_EN: dump entries whose count is zero are not emitted.
//
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_CLEAR    | one-cycle clear kick to the array
//   ST_CLRWAIT  | wait for array clear (first cycle ignored, busy is registered)
//   ST_RUN      | arbitrate hit streams into the accumulate port
//   ST_FLUSH    | drain array write pipeline
//   ST_DUMP_RD  | present read address for current index
//   ST_DUMP_OUT | offer (addr,count) until accepted
module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          finish,
  output logic                          busy,
  output logic                          done,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          acc_clear_kick,
  input  logic                          acc_clear_busy,
  output logic [31:0]                   acc_addr,
  output logic [63:0]                   acc_din,
  output logic                          acc_we,
  input  logic [63:0]                   acc_q,
  output logic                          dump_valid,
  output logic [ADDR_WIDTH-1:0]         dump_addr,
  output logic [COUNT_WIDTH-1:0]        dump_count,
  input  logic                          dump_ready
);

  localparam int PW  = $clog2(NUM_REQ);
  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  state_t                  r_state;
  state_t                  w_next;
  logic [PW-1:0]           r_ptr;
  logic                    r_clr_first;
  logic [FCW-1:0]          r_flush_cnt;
  logic [ADDR_WIDTH-1:0]   r_idx;
  logic                    r_out_first;
  logic [COUNT_WIDTH-1:0]  r_dump_count;
  logic [31:0]             r_acc_addr;
  logic [63:0]             r_acc_din;
  logic                    r_acc_we;
  logic                    r_done;

  logic [NUM_REQ-1:0]      w_grant;
  logic [PW-1:0]           w_gidx;
  logic                    w_gany;
  logic                    w_xfer;
  logic [ADDR_WIDTH-1:0]   w_gaddr;
  logic [COUNT_WIDTH-1:0]  w_dump_cnt;
  logic                    w_skip;
  logic                    w_valid;
  logic                    w_adv;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_rd_idx;
  logic                    w_unused_q;

  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_gany)
  );

  assign w_xfer     = (r_state == ST_RUN) && w_gany;
  assign w_gaddr    = req_addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign w_last     = (r_idx == LAST_IDX);
  assign w_rd_idx   = (r_state == ST_FLUSH) ? '0 : r_idx + ADDR_WIDTH'(1);
  assign w_unused_q = ^acc_q[63:32];

  // First DUMP_OUT cycle shows read data directly; the capture register holds it after.
  assign w_dump_cnt = r_out_first ? acc_q[COUNT_WIDTH-1:0] : r_dump_count;

`ifdef ACCUM_CTRL_SKIP_ZERO_EN
  assign w_skip = (r_state == ST_DUMP_OUT) && (w_dump_cnt == '0);
`else
  assign w_skip = 1'b0;
`endif

  assign w_valid = (r_state == ST_DUMP_OUT) && !w_skip;
  assign w_adv   = (r_state == ST_DUMP_OUT) && (w_skip || dump_ready);

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (start) w_next = ST_CLEAR;
      ST_CLEAR:    w_next = ST_CLRWAIT;
      ST_CLRWAIT:  if (!r_clr_first && !acc_clear_busy) w_next = ST_RUN;
      ST_RUN:      if (finish) w_next = ST_FLUSH;
      ST_FLUSH:    if (r_flush_cnt == '0) w_next = ST_DUMP_RD;
      ST_DUMP_RD:  w_next = ST_DUMP_OUT;
      ST_DUMP_OUT: if (w_adv) w_next = w_last ? ST_IDLE : ST_DUMP_RD;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_clr_first  <= 1'b0;
      r_flush_cnt  <= '0;
      r_idx        <= '0;
      r_out_first  <= 1'b0;
      r_dump_count <= '0;
      r_acc_addr   <= '0;
      r_acc_din    <= '0;
      r_acc_we     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done      <= w_adv && w_last;
      r_clr_first <= (r_state == ST_CLEAR);
      r_out_first <= (r_state == ST_DUMP_RD);
      r_acc_we    <= w_xfer;

      if ((r_state == ST_RUN) && finish)
        r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      else if ((r_state == ST_FLUSH) && (r_flush_cnt != '0))
        r_flush_cnt <= r_flush_cnt - FCW'(1);

      if (w_xfer) begin
        r_acc_addr <= 32'(w_gaddr);
        r_acc_din  <= {32'h0, INC_VALUE};
        r_ptr      <= PW'(next_lane(int'(w_gidx), NUM_REQ));
      end else if (w_next == ST_DUMP_RD) begin
        r_acc_addr <= 32'(w_rd_idx);
      end

      if (r_out_first) r_dump_count <= acc_q[COUNT_WIDTH-1:0];

      if (r_state == ST_FLUSH)
        r_idx <= '0;
      else if (w_adv)
        r_idx <= w_last ? '0 : r_idx + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    busy           = (r_state != ST_IDLE);
    done           = r_done;
    acc_clear_kick = (r_state == ST_CLEAR);
    req_ready      = (r_state == ST_RUN) ? w_grant : '0;
    acc_addr       = r_acc_addr;
    acc_din        = r_acc_din;
    acc_we         = r_acc_we;
    dump_valid     = w_valid;
    dump_addr      = r_idx;
    dump_count     = w_dump_cnt;
  end

endmodule

// File: tb/tb_accum_ctrl.sv
// Scoreboard bench for accum_ctrl with a small behavioural accumulator array.
module tb_accum_ctrl;

  localparam int NR    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           finish = 1'b0;
  logic           busy, done;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]    req_ready;
  logic           acc_clear_kick;
  logic           acc_clear_busy = 1'b0;
  logic [31:0]    acc_addr;
  logic [63:0]    acc_din;
  logic           acc_we;
  logic [63:0]    acc_q = '0;
  logic           dump_valid;
  logic [AW-1:0]  dump_addr;
  logic [31:0]    dump_count;
  logic           dump_ready = 1'b1;

  accum_ctrl #(.NUM_REQ(NR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .busy(busy), .done(done),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .acc_clear_kick(acc_clear_kick), .acc_clear_busy(acc_clear_busy),
    .acc_addr(acc_addr), .acc_din(acc_din), .acc_we(acc_we), .acc_q(acc_q),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_count(dump_count),
    .dump_ready(dump_ready)
  );

  always #5 clk = ~clk;

  // Accumulator array: registered read, accumulate on we, multi-cycle clear.
  logic [63:0] mem [DEPTH];
  int clr_cnt = 0;
  initial for (int i = 0; i < DEPTH; i++) mem[i] = 64'h100 + 64'(i);

  always @(posedge clk) begin
    acc_q <= mem[acc_addr[AW-1:0]];
    if (acc_we) mem[acc_addr[AW-1:0]] <= mem[acc_addr[AW-1:0]] + acc_din;
    if (acc_clear_kick) begin
      acc_clear_busy <= 1'b1;
      clr_cnt        <= 4;
    end else if (acc_clear_busy) begin
      if (clr_cnt == 0) begin
        acc_clear_busy <= 1'b0;
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
        clr_cnt <= clr_cnt - 1;
      end
    end
  end

  typedef struct { int addr; longint cnt; } beat_t;
  beat_t sbq[$];
  int    exp_cnt[DEPTH];
  int    n_chk = 0, n_fail = 0;
  int    n_done = 0, n_kick = 0, kick0 = 0;
  bit    chk_grant = 0, no_ready = 0, rand_ready = 0;
  int    exp_g = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: scoreboard pops on dump handshakes, stall stability, grant order.
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [31:0]   prev_cnt = '0;
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (acc_clear_kick) n_kick++;
      if (done) n_done++;
      if (prev_stall) begin
        check("stall_valid", dump_valid, 1);
        check("stall_addr", dump_addr, prev_addr);
        check("stall_count", dump_count, prev_cnt);
      end
      if (dump_valid && dump_ready) begin
        if (sbq.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL dump_extra_beat: got addr %0d count %0d, none expected", dump_addr, dump_count);
        end else begin
          beat_t b;
          b = sbq.pop_front();
          check("dump_addr", dump_addr, b.addr);
          check("dump_count", dump_count, b.cnt);
        end
      end
      if (chk_grant && req_ready != 0) begin
        check("rr_grant", req_ready, 1 << exp_g);
        exp_g = (exp_g + 1) % NR;
      end
      if (no_ready) check("no_ready_after_finish", req_ready, 0);
      prev_stall = dump_valid && !dump_ready;
      prev_addr  = dump_addr;
      prev_cnt   = dump_count;
    end
  end

  always begin
    @(posedge clk);
    #2;
    dump_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic start_job();
    for (int i = 0; i < DEPTH; i++) exp_cnt[i] = 0;
    kick0 = n_kick;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic hit(input int lane, input int a, input bit with_finish);
    int n;
    n = 0;
    @(negedge clk);
    req_valid[lane]            = 1'b1;
    req_addr[lane*AW +: AW]    = AW'(a);
    finish                     = with_finish;
    #1;
    while (!req_ready[lane] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) fail_now("hit_wait");
    else exp_cnt[a]++;
    check("hit_grant", req_ready, 1 << lane);
    @(posedge clk);
    #1;
    req_valid[lane] = 1'b0;
    finish          = 1'b0;
  endtask

  task automatic push_expected();
    beat_t b;
    for (int i = 0; i < DEPTH; i++) begin
`ifdef ACCUM_CTRL_SKIP_ZERO_EN
      if (exp_cnt[i] == 0) continue;
`endif
      b.addr = i;
      b.cnt  = exp_cnt[i];
      sbq.push_back(b);
    end
  endtask

  task automatic end_job(input bit do_push, input bit do_finish);
    int n, d0;
    if (do_push) push_expected();
    d0 = n_done;
    if (do_finish) begin
      @(negedge clk);
      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
    end
    n = 0;
    while (n_done == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("done_wait");
    repeat (3) @(negedge clk);
    #2;
    check("done_pulses", n_done - d0, 1);
    check("clear_kicks", n_kick - kick0, 1);
    check("scoreboard_drained", sbq.size(), 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_kick"}, acc_clear_kick, 0);
    check({tag, "_acc_we"}, acc_we, 0);
    check({tag, "_acc_addr"}, acc_addr, 0);
    check({tag, "_acc_din"}, acc_din, 0);
    check({tag, "_dump_valid"}, dump_valid, 0);
    check({tag, "_dump_addr"}, dump_addr, 0);
    check({tag, "_dump_count"}, dump_count, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g;
    // Reset state, with all requesters valid to show no grant outside RUN.
    req_valid = '1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("reset");
    req_valid = '0;

    // Single lane: 5,5,7; a start pulse during RUN must be ignored.
    start_job();
    hit(0, 5, 0);
    hit(0, 5, 0);
    hit(0, 7, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    end_job(1, 1);

    // All lanes valid at addr 3: strict rotation from pointer 0, 100 hits.
    do_reset();
    start_job();
    chk_grant = 1;
    exp_g     = 0;
    @(negedge clk);
    req_valid = '1;
    req_addr  = {NR{AW'(3)}};
    #1;
    n = 0;
    g = 0;
    while (n < 100 && g < 400) begin
      if (req_ready != 0) n++;
      if (n < 100) begin
        @(negedge clk);
        #1;
        g++;
      end
    end
    if (g >= 400) fail_now("rr_hits");
    @(posedge clk);
    #1;
    req_valid = '0;
    chk_grant = 0;
    exp_cnt[3] = 100;
    end_job(1, 1);

    // Last hit coincides with finish; FLUSH holds four cycles with no further grants.
    start_job();
    hit(1, 10, 0);
    hit(2, 12, 1);
    push_expected();
    no_ready     = 1;
    req_valid[0] = 1'b1;
    check("flush0_we", acc_we, 1);
    check("flush0_addr", acc_addr, 12);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk);
      #1;
      check("flush_we", acc_we, 0);
      check("flush_addr", acc_addr, 12);
      check("flush_dump_valid", dump_valid, 0);
    end
    @(posedge clk);
    #1;
    check("dump_rd_addr", acc_addr, 0);
    end_job(0, 0);
    no_ready     = 0;
    req_valid[0] = 1'b0;

    // Random backpressure on the dump stream, boundary indices 0 and last.
    rand_ready = 1;
    start_job();
    hit(2, 0, 0);
    hit(2, DEPTH - 1, 0);
    hit(1, 6, 0);
    hit(1, 6, 0);
    hit(1, 6, 0);
    end_job(1, 1);
    rand_ready = 0;

    // Reset while dumping returns every output to its reset value.
    start_job();
    hit(3, 4, 0);
    push_expected();
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    #1;
    n = 0;
    while (!dump_valid && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) fail_now("dump_valid_wait");
    reset     = 1'b1;
    req_valid = '1;
    @(posedge clk);
    #1;
    check_idle_outputs("mid_dump_reset");
    @(negedge clk);
    reset     = 1'b0;
    req_valid = '0;
    sbq.delete();

    // Hits at 1 and 9 (only two beats when zero entries are skipped).
    start_job();
    hit(3, 1, 0);
    hit(0, 9, 0);
    end_job(1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
